spi_jtag_bridge: RTL and testbench

Parametrised JTAG-to-SPI flash bridge, the successor to the single-channel, unbounded-shift SPI-over-JTAG bridge. It sits between a vendor virtual-JTAG primitive (tdi/tdo/ir_in/virtual states) and one or more SPI flash devices. The host selects a command byte and chip select through the user IR, then sends a byte-length header in DR. The bridge clocks exactly that many bytes to the selected flash and frees the host from trailing-bit hazards. It adds multi-CS, bounded transfers, abort detection and status.

---
 rtl/spi_jtag_bridge.sv | 241 ++++++++++++++++++++++++
 tb/tb_spi_jtag_bridge.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_jtag_bridge.sv
// -----------------------------------------------------------------------------
// spi_jtag_bridge
//
// Bridges a vendor virtual-JTAG primitive to one or more SPI flash devices
// (SPI mode 0). The host loads a command byte and a chip-select index through
// the user IR. It then enters shift-DR and sends a LEN_WIDTH-bit length header
// L, LSB first. The bridge clocks exactly 8*(L+1) bits to the selected flash:
// the command byte LSB first, then the host's tdi bits. Any bits the host
// shifts after that are bypassed from tdi to tdo and never reach the flash.
//
// Parameters
//   IR_WIDTH  : user IR width; [7:0] command byte, [IR_WIDTH-1:8] CS index
//   CS_WIDTH  : number of chip selects
//   LEN_WIDTH : width of the byte-length header
//
// Ports
//   tck       in   sole clock, all state updates on posedge
//   rst_n     in   synchronous reset, active low
//   ir_in     in   user IR value, captured on vs_uir
//   vs_uir    in   virtual update-IR state
//   vs_cdr    in   virtual capture-DR state
//   vs_sdr    in   virtual shift-DR state
//   tdi       in   JTAG data in
//   tdo       out  JTAG data out (registered miso in XFER, else tdi delayed)
//   spi_clk   out  SPI clock = ~tck gated by a registered enable
//   spi_csn   out  active-low chip selects
//   spi_mosi  out  registered serial data to flash
//   spi_miso  in   serial data from flash
//   busy      out  high while in HDR or XFER
//   aborted   out  sticky: last transaction left shift-DR early
// -----------------------------------------------------------------------------
module spi_jtag_bridge #(
   parameter int IR_WIDTH  = 9,
   parameter int CS_WIDTH  = 1,
   parameter int LEN_WIDTH = 16
) (
   input  logic                tck,
   input  logic                rst_n,
   input  logic [IR_WIDTH-1:0] ir_in,
   input  logic                vs_uir,
   input  logic                vs_cdr,
   input  logic                vs_sdr,
   input  logic                tdi,
   output logic                tdo,
   output logic                spi_clk,
   output logic [CS_WIDTH-1:0] spi_csn,
   output logic                spi_mosi,
   input  logic                spi_miso,
   output logic                busy,
   output logic                aborted
);

   localparam int CSI_W = IR_WIDTH - 8;
   // One bit wider than LEN_WIDTH+3 so that 8*(2^LEN_WIDTH) fits without wrap.
   localparam int CNT_W = LEN_WIDTH + 4;
   localparam int HC_W  = (LEN_WIDTH > 1) ? $clog2(LEN_WIDTH) : 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(LEN_WIDTH - 1);
   localparam logic [31:0]     CS_LIM  = 32'(CS_WIDTH);
   localparam logic [CS_WIDTH-1:0] CSN_IDLE = {CS_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_XFER = 2'd2,
      ST_TAIL = 2'd3
   } state_e;

   state_e               state_q, state_d;
   logic [7:0]           cmd_q, cmd_d;
   logic [CSI_W-1:0]     cs_q, cs_d;
   logic [7:0]           sr_q, sr_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;
   logic [HC_W-1:0]      hcnt_q, hcnt_d;
   logic [CNT_W-1:0]     bcnt_q, bcnt_d;
   logic                 clk_en_q, clk_en_d;
   logic [CS_WIDTH-1:0]  csn_q, csn_d;
   logic                 mosi_q, mosi_d;
   logic                 busy_q, busy_d;
   logic                 aborted_q, aborted_d;
   logic                 tdi_q;
   logic                 miso_q;

   logic                 cs_valid_s;
   logic [CS_WIDTH-1:0]  csn_sel_s;
   logic [CNT_W-1:0]     total_s;
   logic                 abort_s;

   // An out-of-range CS index turns the transaction into a null one.
   assign cs_valid_s = (32'(cs_q) < CS_LIM);
   assign csn_sel_s  = ~(CS_WIDTH'(1) << cs_q);
   // Bits clocked to the flash: command byte plus L payload bytes.
   assign total_s    = CNT_W'({len_q, 3'b000}) + CNT_W'(8);

   // clk_en only changes on posedge tck, while ~tck is low, so no runt pulses.
   assign spi_clk  = ~tck & clk_en_q;
   assign spi_csn  = csn_q;
   assign spi_mosi = mosi_q;
   assign busy     = busy_q;
   assign aborted  = aborted_q;
   assign tdo      = ((state_q == ST_XFER) && cs_valid_s) ? miso_q : tdi_q;

   // Next-state and datapath update for the transaction sequencer.
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      cs_d      = cs_q;
      sr_d      = sr_q;
      len_d     = len_q;
      hcnt_d    = hcnt_q;
      bcnt_d    = bcnt_q;
      clk_en_d  = clk_en_q;
      csn_d     = csn_q;
      mosi_d    = mosi_q;
      aborted_d = aborted_q;
      abort_s   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (vs_cdr) begin
               sr_d    = cmd_q;
               hcnt_d  = '0;
               state_d = ST_HDR;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_HDR: begin
            if (vs_cdr || !vs_sdr) begin
               abort_s = 1'b1;
            end else begin
               // Length arrives LSB first: new bit enters at the top.
               len_d  = (LEN_WIDTH'(tdi) << (LEN_WIDTH - 1)) | (len_q >> 1);
               hcnt_d = hcnt_q + HC_W'(1);
               if (hcnt_q == HC_LAST) begin
                  bcnt_d  = '0;
                  state_d = ST_XFER;
               end else begin
                  state_d = ST_HDR;
               end
            end
         end

         ST_XFER: begin
            // Completion is checked first so that a host shifting exactly the
            // required number of bits is not flagged as an abort.
            if (bcnt_q == total_s) begin
               clk_en_d = 1'b0;
               csn_d    = CSN_IDLE;
               state_d  = ST_TAIL;
            end else if (vs_cdr || !vs_sdr) begin
               abort_s = 1'b1;
            end else begin
               mosi_d = sr_q[0];
               sr_d   = {tdi, sr_q[7:1]};
               bcnt_d = bcnt_q + CNT_W'(1);
               if (cs_valid_s) begin
                  clk_en_d = 1'b1;
                  csn_d    = csn_sel_s;
               end else begin
                  clk_en_d = 1'b0;
                  csn_d    = CSN_IDLE;
               end
            end
         end

         ST_TAIL: begin
            if (vs_cdr) begin
               abort_s = 1'b1;
            end else if (!vs_sdr) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_TAIL;
            end
         end

         default: begin
            clk_en_d = 1'b0;
            csn_d    = CSN_IDLE;
            state_d  = ST_IDLE;
         end
      endcase

      if (abort_s) begin
         clk_en_d  = 1'b0;
         csn_d     = CSN_IDLE;
         aborted_d = 1'b1;
         state_d   = ST_IDLE;
      end else begin
         aborted_d = aborted_d;
      end

      // Update-IR loads the next command and clears the abort flag.
      if (vs_uir) begin
         cmd_d     = ir_in[7:0];
         cs_d      = ir_in[IR_WIDTH-1:8];
         aborted_d = 1'b0;
      end else begin
         cmd_d = cmd_q;
         cs_d  = cs_q;
      end

      busy_d = (state_d == ST_HDR) || (state_d == ST_XFER);
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge tck) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cmd_q     <= 8'h00;
         cs_q      <= '0;
         sr_q      <= 8'h00;
         len_q     <= '0;
         hcnt_q    <= '0;
         bcnt_q    <= '0;
         clk_en_q  <= 1'b0;
         csn_q     <= CSN_IDLE;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         aborted_q <= 1'b0;
         tdi_q     <= 1'b0;
         miso_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         cs_q      <= cs_d;
         sr_q      <= sr_d;
         len_q     <= len_d;
         hcnt_q    <= hcnt_d;
         bcnt_q    <= bcnt_d;
         clk_en_q  <= clk_en_d;
         csn_q     <= csn_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         aborted_q <= aborted_d;
         tdi_q     <= tdi;
         miso_q    <= spi_miso;
      end
   end

endmodule

// File: tb/tb_spi_jtag_bridge.sv
// -----------------------------------------------------------------------------
// tb_spi_jtag_bridge
//
// Drives JTAG-style transactions into spi_jtag_bridge (4 chip selects, 4-bit
// length header) and checks pulse counts, the MOSI bit stream, chip-select
// behaviour, tdo routing, busy/aborted and reset. A behavioural flash answers
// every command with a reply bit stream (the JEDEC ID 0xEF4018 for 0x9F).
// -----------------------------------------------------------------------------
module tb_spi_jtag_bridge;

   localparam int IR_W  = 11;
   localparam int CS_W  = 4;
   localparam int LEN_W = 4;

   logic            tck    = 1'b0;
   logic            rst_n  = 1'b0;
   logic [IR_W-1:0] ir_in  = '0;
   logic            vs_uir = 1'b0;
   logic            vs_cdr = 1'b0;
   logic            vs_sdr = 1'b0;
   logic            tdi    = 1'b0;
   logic            tdo;
   logic            spi_clk;
   logic [CS_W-1:0] spi_csn;
   logic            spi_mosi;
   logic            spi_miso;
   logic            busy;
   logic            aborted;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;
   int csn_err   = 0;
   logic [CS_W-1:0] exp_mask = 4'hF;
   bit   mosi_log [int];
   logic rsp      [0:127];
   logic tdi_log  [0:255];

   typedef struct {
      logic [7:0] cmd;
      logic [2:0] cs;
      int         len;
      int         nbits;
      bit         abrt;
      int         exp_pulses;
   } vec_t;

   spi_jtag_bridge #(
      .IR_WIDTH (IR_W),
      .CS_WIDTH (CS_W),
      .LEN_WIDTH(LEN_W)
   ) dut (
      .tck     (tck),
      .rst_n   (rst_n),
      .ir_in   (ir_in),
      .vs_uir  (vs_uir),
      .vs_cdr  (vs_cdr),
      .vs_sdr  (vs_sdr),
      .tdi     (tdi),
      .tdo     (tdo),
      .spi_clk (spi_clk),
      .spi_csn (spi_csn),
      .spi_mosi(spi_mosi),
      .spi_miso(spi_miso),
      .busy    (busy),
      .aborted (aborted)
   );

   always #5 tck = ~tck;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: pulses follow only from CS range, length and abort point.
   function automatic int ref_pulses(input logic [2:0] cs, input int len, input int nbits, input bit abrt);
      if (int'(cs) >= CS_W) return 0;
      if (abrt) return nbits;
      return 8 * (len + 1);
   endfunction

   // Behavioural SPI mode-0 flash: samples mosi on spi_clk rise, drives the
   // reply after each fall once the 8 command bits are in; also checks csn.
   initial begin : flash_model
      int fall_k;
      bit rose;
      fall_k   = 0;
      rose     = 1'b0;
      spi_miso = 1'b0;
      forever begin
         @(negedge tck);
         #1;
         if (spi_clk === 1'b1) begin
            mosi_log[pulse_cnt] = spi_mosi;
            pulse_cnt++;
            rose = 1'b1;
         end
         if (spi_csn !== ((spi_clk === 1'b1) ? exp_mask : 4'hF)) csn_err++;
         @(posedge tck);
         #1;
         if (rose) begin
            fall_k++;
            spi_miso = (fall_k >= 8) ? rsp[fall_k-8] : 1'b0;
            rose = 1'b0;
         end
         if (spi_csn === 4'hF) begin
            fall_k   = 0;
            spi_miso = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   task automatic load_ir(input logic [2:0] cs, input logic [7:0] cmd);
      ir_in  = {cs, cmd};
      vs_uir = 1'b1;
      tick();
      vs_uir = 1'b0;
   endtask

   task automatic run_txn(input vec_t v);
      int total, j, mism, p0, e0;
      bit active;
      logic [LEN_W-1:0] lv;
      logic [23:0] id;
      logic exp_tdo;
      total  = 8 * (v.len + 1);
      active = (int'(v.cs) < CS_W);
      exp_mask = active ? ~(4'b0001 << v.cs) : 4'hF;
      id = 24'hEF4018;
      for (int r = 0; r < 128; r++)
         rsp[r] = (v.cmd == 8'h9F && r < 24) ? id[23-r] : 1'($urandom);
      p0 = pulse_cnt;
      e0 = csn_err;

      load_ir(v.cs, v.cmd);
      check("uir_clears_aborted", 32'(aborted), 32'd0);
      vs_cdr = 1'b1;
      tick();
      vs_cdr = 1'b0;
      check("busy_after_capture", 32'(busy), 32'd1);

      lv = LEN_W'(v.len);
      for (int h = 0; h < LEN_W; h++) begin
         vs_sdr = 1'b1;
         tdi    = lv[h];
         tick();
         if (h < LEN_W - 1) check("tdo_hdr_bypass", 32'(tdo), 32'(lv[h]));
      end

      for (int b = 0; b < v.nbits; b++) begin
         tdi = 1'($urandom);
         tdi_log[b] = tdi;
         tick();
         j = b + 1;
         check("busy_xfer", 32'(busy), (v.abrt || j <= total) ? 32'd1 : 32'd0);
         if (!active || j > total) exp_tdo = tdi_log[b];
         else if (j >= 10) exp_tdo = rsp[j-10];
         else exp_tdo = 1'b0;
         check("tdo_stream", 32'(tdo), 32'(exp_tdo));
      end

      vs_sdr = 1'b0;
      tdi    = 1'b0;
      tick();
      if (v.abrt) begin
         check("abort_csn_high", 32'(spi_csn), 32'hF);
         check("abort_flag", 32'(aborted), 32'd1);
      end else begin
         check("complete_no_abort", 32'(aborted), 32'd0);
      end
      check("busy_after_txn", 32'(busy), 32'd0);
      tick();
      tick();

      check("spi_clk_pulses", 32'(pulse_cnt - p0), 32'(v.exp_pulses));
      mism = 0;
      for (int k = 0; k < pulse_cnt - p0; k++) begin
         exp_tdo = (k < 8) ? v.cmd[k] : tdi_log[k-8];
         if (mosi_log[p0+k] != exp_tdo) mism++;
      end
      check("mosi_stream_bit_errors", 32'(mism), 32'd0);
      check("csn_pattern_errors", 32'(csn_err - e0), 32'd0);
   endtask

   initial begin : main
      vec_t vecs[$];
      vec_t v;

      // Directed table: read ID, overshift, multi-CS, null CS, L=0, L=max, aborts.
      vecs.push_back('{8'h9F, 3'd0,  3,  33, 1'b0,  32});
      vecs.push_back('{8'h03, 3'd0,  1,  40, 1'b0,  16});
      vecs.push_back('{8'hAB, 3'd2,  2,  25, 1'b0,  24});
      vecs.push_back('{8'hAB, 3'd5,  2,  25, 1'b0,   0});
      vecs.push_back('{8'h06, 3'd1,  0,   9, 1'b0,   8});
      vecs.push_back('{8'h0B, 3'd3, 15, 129, 1'b0, 128});
      vecs.push_back('{8'h9F, 3'd0,  3,  12, 1'b1,  12});
      vecs.push_back('{8'h55, 3'd7,  1,   5, 1'b1,   0});
      for (int i = 0; i < 12; i++) begin
         v.cmd  = 8'($urandom);
         v.cs   = 3'($urandom_range(0, 5));
         v.len  = int'($urandom_range(0, 15));
         v.abrt = ($urandom_range(0, 3) == 0);
         if (v.abrt) v.nbits = int'($urandom_range(0, 8 * (v.len + 1) - 1));
         else        v.nbits = 8 * (v.len + 1) + 1 + int'($urandom_range(0, 8));
         v.exp_pulses = ref_pulses(v.cs, v.len, v.nbits, v.abrt);
         vecs.push_back(v);
      end

      // Reset state.
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_csn", 32'(spi_csn), 32'hF);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      check("rst_tdo", 32'(tdo), 32'd0);
      check("rst_mosi", 32'(spi_mosi), 32'd0);
      @(negedge tck);
      #1;
      check("rst_spi_clk", 32'(spi_clk), 32'd0);
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) run_txn(vecs[i]);

      // Abort during the header, then update-IR clears the flag.
      exp_mask = 4'hE;
      load_ir(3'd0, 8'h9F);
      vs_cdr = 1'b1;
      tick();
      vs_cdr = 1'b0;
      vs_sdr = 1'b1;
      tdi    = 1'b1;
      tick();
      tick();
      vs_sdr = 1'b0;
      tick();
      check("hdr_abort_flag", 32'(aborted), 32'd1);
      check("hdr_abort_busy", 32'(busy), 32'd0);
      check("hdr_abort_csn", 32'(spi_csn), 32'hF);
      load_ir(3'd0, 8'h05);
      check("uir_clear_after_abort", 32'(aborted), 32'd0);

      // Reset in the middle of XFER truncates without setting aborted.
      load_ir(3'd0, 8'h9F);
      vs_cdr = 1'b1;
      tick();
      vs_cdr = 1'b0;
      for (int h = 0; h < LEN_W; h++) begin
         vs_sdr = 1'b1;
         tdi    = (h < 2) ? 1'b1 : 1'b0;
         tick();
      end
      for (int b = 0; b < 10; b++) begin
         tdi = 1'($urandom);
         tick();
      end
      check("mid_xfer_csn_low", 32'(spi_csn), 32'hE);
      rst_n = 1'b0;
      tick();
      check("midrst_csn", 32'(spi_csn), 32'hF);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_aborted", 32'(aborted), 32'd0);
      @(negedge tck);
      #1;
      check("midrst_spi_clk", 32'(spi_clk), 32'd0);
      tick();
      tick();
      vs_sdr = 1'b0;
      rst_n  = 1'b1;
      tick();

      // Recovery after reset.
      run_txn(vecs[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
